nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that computes S = A + B + Cin one 4-bit nibble per clock.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_adder4.sv | 13 +
 rtl/nibble_serial_adder.sv | 109 ++++++++++
 tb/tb_nibble_serial_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: datapath slice width,
// FSM state encoding and the nibble-index width helper.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-nibble datapath still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// 4-bit ripple adder slice: {C4, S} = A + B + C0.
// Shared by every nibble of a serial add.
module adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic [3:0] S,
  output logic       C4
);

  assign {C4, S} = {1'b0, A} + {1'b0, B} + {4'b0000, C0};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder computing S = A + B + Cin one nibble per clock,
// LSB first, through one shared adder4 with the nibble carry held in a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef logic [NIB-1:0][NIBBLE_W-1:0] nib_vec_t;

  state_e           state_q;
  nib_vec_t         a_q;
  nib_vec_t         b_q;
  nib_vec_t         s_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIBBLE_W-1:0] sum_d;
  logic                carry_d;
  logic                accept;

  // A new request is taken only between adds; start during RUN is dropped.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  adder4 u_adder4 (
    .A  (a_q[idx_q]),
    .B  (b_q[idx_q]),
    .C0 (carry_q),
    .S  (sum_d),
    .C4 (carry_d)
  );

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before any RUN cycle reads them, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all updates
  // within one edge see the pre-edge values of state_q, idx_q and carry_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          s_q[idx_q] <= sum_d;
          carry_q    <= carry_d;
          if (idx_q == LAST_IDX) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        // IDLE and DONE both accept; DONE falls back to IDLE when no start.
        default: begin
          if (accept) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            carry_q <= Cin;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: vector table with a result
// scoreboard on a 16-bit instance, plus multi-cycle corner cases and a 4-bit instance.
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_s;
    logic        exp_cout;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic        busy4;
  logic        done4;
  logic [3:0]  s4;
  logic        cout4;

  res_t sb_q[$];
  res_t mon_exp;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .S(s), .Cout(cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen; cyc counts post-edge cycles since the accept edge.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 1;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      step();
      cyc++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] es, input logic ec);
    int cyc;
    int bcnt;
    start = 1'b1; a = av; b = bv; cin = ci;
    sb_q.push_back('{s: es, cout: ec});
    step();
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(cyc, bcnt);
    check("done_latency", 32'(cyc), 32'd5);
    check("busy_cycles", 32'(bcnt), 32'd4);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("hold_s", 32'(s), 32'(es));
    check("hold_cout", 32'(cout), 32'(ec));
  endtask

  // Scoreboard side: every done pulse must match the oldest pending result.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      check("busy_done_exclusive", 32'(busy && done), 32'd0);
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_exp = sb_q.pop_front();
          check("result_s", 32'(s), 32'(mon_exp.s));
          check("result_cout", 32'(cout), 32'(mon_exp.cout));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   cyc;
    int   bcnt;
    int   d0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_s4", 32'(s4), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_s, vecs[i].exp_cout);
      step();
    end

    // start and new operands during RUN must be ignored.
    d0 = done_cnt;
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    sb_q.push_back('{s: 16'h3333, cout: 1'b0});
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 16'h0F0F; b = 16'h0F0F; cin = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; bcnt = 0;
    wait_done(cyc, bcnt);
    check("ignored_start_latency", 32'(cyc + 2), 32'd5);
    repeat (8) step();
    check("ignored_start_one_done", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Reset in the third RUN cycle aborts without a done pulse.
    d0 = done_cnt;
    start = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b1;
    sb_q.push_back('{s: 16'hBCDF, cout: 1'b0});
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    sb_q.delete();
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    repeat (8) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_add(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);
    step();

    // Back-to-back: start held in the done cycle is accepted with no gap.
    start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    sb_q.push_back('{s: 16'h2345, cout: 1'b0});
    step();
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("b2b_first_latency", 32'(cyc), 32'd5);
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    sb_q.push_back('{s: 16'h0002, cout: 1'b0});
    step();
    start = 1'b0;
    check("b2b_busy_rises", 32'(busy), 32'd1);
    check("b2b_done_drops", 32'(done), 32'd0);
    wait_done(cyc, bcnt);
    check("b2b_second_latency", 32'(cyc), 32'd5);
    check("b2b_second_s", 32'(s), 32'h0002);
    repeat (3) step();

    // Single-nibble instance: one busy cycle, done on the second edge.
    start4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
    step();
    start4 = 1'b0;
    check("w4_busy", 32'(busy4), 32'd1);
    check("w4_no_done_yet", 32'(done4), 32'd0);
    step();
    check("w4_busy_drop", 32'(busy4), 32'd0);
    check("w4_done", 32'(done4), 32'd1);
    check("w4_s", 32'(s4), 32'h1);
    check("w4_cout", 32'(cout4), 32'd1);
    step();
    check("w4_done_pulse", 32'(done4), 32'd0);
    check("w4_hold_s", 32'(s4), 32'h1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
